// File: rtl/psg_bus_regs.sv
// PSG register file R0-R15 with the AY-3-891x BDIR/BC1 bus decoder and an envelope restart strobe.
// Optional macro PSG_BUS_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module psg_bus_regs #(
    parameter logic [3:0] CHIP_ADDR = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [7:0]  mixer_ctrl,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic [3:0]  env_shape,
    output logic        env_restart,
    output logic [7:0]  io_a,
    output logic [7:0]  io_b
);

    typedef enum logic [1:0] {
        MODE_INACTIVE = 2'b00,
        MODE_READ     = 2'b01,
        MODE_WRITE    = 2'b10,
        MODE_LATCH    = 2'b11
    } bus_mode_e;

    logic [9:0] bus_s;

`ifdef PSG_BUS_SYNC_EN
    logic [9:0] sync1_q;
    logic [9:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bdir, bc1, data_in};
            sync2_q <= sync1_q;
        end
    end

    assign bus_s = sync2_q;
`else
    assign bus_s = {bdir, bc1, data_in};
`endif

    bus_mode_e  mode;
    logic [7:0] din;

    assign mode = bus_mode_e'(bus_s[9:8]);
    assign din  = bus_s[7:0];

    // Implemented width of each register; unimplemented bits are stored and read as 0.
    function automatic logic [7:0] width_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: width_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: width_mask = 8'h1F;
            default:                 width_mask = 8'hFF;
        endcase
    endfunction

    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [3:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       restart_q, restart_d;
    bus_mode_e  prev_q, prev_d;

    always_comb begin
        regs_d    = regs_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        dout_d    = 8'h00;
        doe_d     = 1'b0;
        restart_d = 1'b0;
        prev_d    = mode;
        case (mode)
            MODE_LATCH: begin
                addr_d = din[3:0];
                sel_d  = (din[7:4] == CHIP_ADDR);
            end
            MODE_WRITE: begin
                if (sel_q) begin
                    regs_d[addr_q] = din & width_mask(addr_q);
                    // Only the first cycle of a write phase restarts the envelope.
                    restart_d = (prev_q != MODE_WRITE) && (addr_q == 4'd13);
                end
            end
            MODE_READ: begin
                if (sel_q) begin
                    doe_d  = 1'b1;
                    dout_d = regs_q[addr_q];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '{default: 8'h00};
            addr_q    <= 4'd0;
            sel_q     <= 1'b1;
            dout_q    <= 8'h00;
            doe_q     <= 1'b0;
            restart_q <= 1'b0;
            prev_q    <= MODE_INACTIVE;
        end else begin
            regs_q    <= regs_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            restart_q <= restart_d;
            prev_q    <= prev_d;
        end
    end

    assign data_out      = dout_q;
    assign data_oe       = doe_q;
    assign env_restart   = restart_q;
    assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
    assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
    assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
    assign noise_period  = regs_q[6][4:0];
    assign mixer_ctrl    = regs_q[7];
    assign amp_a         = regs_q[8][4:0];
    assign amp_b         = regs_q[9][4:0];
    assign amp_c         = regs_q[10][4:0];
    assign env_period    = {regs_q[12], regs_q[11]};
    assign env_shape     = regs_q[13][3:0];
    assign io_a          = regs_q[14];
    assign io_b          = regs_q[15];

endmodule

// File: tb/tb_psg_bus_regs.sv
// Scoreboard bench for psg_bus_regs: a behavioural bus model queues the expected output
// vector for every driven cycle and each test pops and compares when the DUT responds.
module tb_psg_bus_regs;

`ifdef PSG_BUS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam logic [1:0] INA = 2'b00, RD = 2'b01, WR = 2'b10, LA = 2'b11;

    typedef logic [109:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bdir = 1'b0;
    logic        bc1 = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period, amp_a, amp_b, amp_c;
    logic [7:0]  mixer_ctrl, io_a, io_b;
    logic [15:0] env_period;
    logic [3:0]  env_shape;
    logic        env_restart;

    psg_bus_regs #(.CHIP_ADDR(4'b0000)) dut (
        .clk(clk), .reset(reset), .bdir(bdir), .bc1(bc1), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe),
        .tone_period_a(tone_period_a), .tone_period_b(tone_period_b), .tone_period_c(tone_period_c),
        .noise_period(noise_period), .mixer_ctrl(mixer_ctrl),
        .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
        .env_period(env_period), .env_shape(env_shape), .env_restart(env_restart),
        .io_a(io_a), .io_b(io_b)
    );

    always #5 clk = ~clk;

    vec_t obs;
    assign obs = {data_out, data_oe, env_restart, tone_period_a, tone_period_b, tone_period_c,
                  noise_period, mixer_ctrl, amp_a, amp_b, amp_c, env_period, env_shape, io_a, io_b};

    int total = 0;
    int bad = 0;
    vec_t sb[$];

    // Behavioural model of the bus protocol
    logic [7:0] m_regs [16];
    logic [3:0] m_addr;
    logic       m_sel;
    logic [1:0] m_prev;
    logic [7:0] m_dout;
    logic       m_doe;
    logic       m_rst;
    int         widths [16] = '{8, 4, 8, 4, 8, 4, 5, 8, 5, 5, 5, 8, 8, 4, 8, 8};

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_addr = 4'd0; m_sel = 1'b1; m_prev = INA;
        m_dout = 8'h00; m_doe = 1'b0; m_rst = 1'b0;
    endtask

    task automatic m_apply(input logic [1:0] mode, input logic [7:0] d);
        logic [8:0] full;
        m_rst  = (mode == WR) && (m_prev != WR) && m_sel && (m_addr == 4'd13);
        m_doe  = (mode == RD) && m_sel;
        m_dout = m_doe ? m_regs[m_addr] : 8'h00;
        if (mode == WR && m_sel) begin
            full = (9'd1 << widths[m_addr]) - 9'd1;
            m_regs[m_addr] = d & full[7:0];
        end
        if (mode == LA) begin
            m_addr = d[3:0];
            m_sel  = (d[7:4] == 4'h0);
        end
        m_prev = mode;
    endtask

    function automatic vec_t m_vec();
        return {m_dout, m_doe, m_rst, m_regs[1][3:0], m_regs[0], m_regs[3][3:0], m_regs[2],
                m_regs[5][3:0], m_regs[4], m_regs[6][4:0], m_regs[7], m_regs[8][4:0],
                m_regs[9][4:0], m_regs[10][4:0], m_regs[12], m_regs[11], m_regs[13][3:0],
                m_regs[14], m_regs[15]};
    endfunction

    // Drive one bus cycle, queue its expectation, and return the expectation due now.
    task automatic step(input logic [1:0] mode, input logic [7:0] d, output vec_t e);
        {bdir, bc1} = mode;
        data_in = d;
        m_apply(mode, d);
        sb.push_back(m_vec());
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [7:0] d);
        reset = 1'b1;
        {bdir, bc1} = mode;
        data_in = d;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        sb.delete();
        repeat (LAT - 1) sb.push_back(m_vec());
    endtask

    task automatic drain();
        vec_t e;
        repeat (LAT - 1) step(INA, 8'h00, e);
    endtask

    task automatic test_reset();
        vec_t e;
        do_reset(INA, 8'h00);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
        for (int n = 0; n < 16; n++) begin
            step(LA, 8'(n), e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL rst_latch%0d got=%h want=%h", n, obs, e); end
            step(RD, 8'h00, e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL rst_read%0d got=%h want=%h", n, obs, e); end
        end
    endtask

    task automatic test_tone();
        vec_t e;
        logic [1:0] md [6] = '{LA, WR, LA, WR, LA, RD};
        logic [7:0] dv [6] = '{8'h01, 8'hFF, 8'h00, 8'h34, 8'h01, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(md[i], dv[i], e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL tone_step%0d got=%h want=%h", i, obs, e); end
        end
        drain();
        total++;
        if (tone_period_a !== 12'hF34) begin bad++; $display("FAIL tone_a got=%h want=f34", tone_period_a); end
    endtask

    task automatic test_env();
        vec_t e;
        int pulses;
        step(LA, 8'h0D, e);
        for (int ph = 0; ph < 2; ph++) begin
            pulses = 0;
            for (int i = 0; i < 5 + LAT; i++) begin
                step((i < 5) ? WR : INA, 8'h0A, e);
                pulses += int'(env_restart);
                total++;
                if (obs !== e) begin bad++; $display("FAIL env_ph%0d_c%0d got=%h want=%h", ph, i, obs, e); end
            end
            total++;
            if (pulses != 1) begin bad++; $display("FAIL env_pulses_ph%0d got=%0d want=1", ph, pulses); end
            total++;
            if (env_shape !== 4'hA) begin bad++; $display("FAIL env_shape got=%h want=a", env_shape); end
        end
    endtask

    task automatic test_chip_select();
        vec_t e;
        logic [1:0] md [6] = '{LA, WR, RD, LA, WR, RD};
        logic [7:0] dv [6] = '{8'h18, 8'h55, 8'h00, 8'h08, 8'h3F, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(md[i], dv[i], e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL csel_step%0d got=%h want=%h", i, obs, e); end
        end
        drain();
        total++;
        if (amp_a !== 5'h1F) begin bad++; $display("FAIL amp_a got=%h want=1f", amp_a); end
    endtask

    task automatic test_mask();
        vec_t e;
        logic [1:0] md [6] = '{LA, WR, LA, WR, LA, RD};
        logic [7:0] dv [6] = '{8'h06, 8'hFF, 8'h0A, 8'hFF, 8'h06, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(md[i], dv[i], e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL mask_step%0d got=%h want=%h", i, obs, e); end
        end
        drain();
        total++;
        if (noise_period !== 5'h1F || amp_c !== 5'h1F) begin
            bad++; $display("FAIL mask_vals got=%h/%h want=1f/1f", noise_period, amp_c);
        end
    endtask

    task automatic test_back_to_back();
        vec_t e;
        logic [1:0] md;
        logic [7:0] d;
        for (int i = 0; i < 60; i++) begin
            md = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (md == LA && d[7:4] > 4'h1) d[7:4] = 4'h0;
            step(md, d, e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, obs, e); end
        end
        drain();
    endtask

    task automatic test_reset_mid_write();
        vec_t e;
        step(LA, 8'h0D, e);
        step(WR, 8'h05, e);
        step(WR, 8'h05, e);
        do_reset(WR, 8'h05);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", obs); end
        for (int i = 0; i < 2 + LAT; i++) begin
            step(WR, 8'h07, e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL midrst_hold%0d got=%h want=%h", i, obs, e); end
        end
        step(LA, 8'h0D, e);
        for (int i = 0; i < 2 + LAT; i++) begin
            step((i < 2) ? WR : INA, 8'h07, e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL midrst_relatch%0d got=%h want=%h", i, obs, e); end
        end
        total++;
        if (env_shape !== 4'h7 || tone_period_a !== 12'h007) begin
            bad++; $display("FAIL midrst_regs got=%h/%h want=7/007", env_shape, tone_period_a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        test_reset();
        test_tone();
        test_env();
        test_chip_select();
        test_mask();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psg_bus_regs.md
Name: psg_bus_regs

Overview:
- Register file and CPU bus interface of the PSG. It decodes the AY-3-891x BDIR/BC1 bus protocol and holds the 16 programmable registers R0–R15.
- It feeds the tone, noise, envelope and mixer stages:
  - 12-bit tone periods to the three tone generators;
  - noise period, mixer control, amplitudes and envelope settings to the downstream stages.
- It also issues a one-cycle envelope restart strobe whenever R13 is written.

Parameters:
- CHIP_ADDR, 4'b0000, required value of data_in[7:4] during address latch for the chip to be selected.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bdir  input  1  bus direction, AY protocol
- bc1  input  1  bus control 1, AY protocol
- data_in  input  8  CPU data/address bus in
- data_out  output  8  read data
- data_oe  output  1  high while read data is driven
- tone_period_a  output  12  {R1[3:0],R0}
- tone_period_b  output  12  {R3[3:0],R2}
- tone_period_c  output  12  {R5[3:0],R4}
- noise_period  output  5  R6[4:0]
- mixer_ctrl  output  8  R7
- amp_a  output  5  R8[4:0]; bit4 = envelope mode
- amp_b  output  5  R9[4:0]
- amp_c  output  5  R10[4:0]
- env_period  output  16  {R12,R11}
- env_shape  output  4  R13[3:0]
- env_restart  output  1  one-cycle pulse after an R13 write
- io_a  output  8  R14
- io_b  output  8  R15

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high, port reset.
  - All inputs are sampled on the rising edge of clk.
- Bus mode is decoded from {bdir,bc1}:
  - 00 = INACTIVE
  - 01 = READ
  - 10 = WRITE
  - 11 = LATCH
- LATCH:
  - addr <= data_in[3:0].
  - selected <= (data_in[7:4] == CHIP_ADDR).
  - Both are visible from the next cycle.
- WRITE, when selected:
  - The register at addr is loaded with data_in, masked to its width.
  - Widths are 4 bits for R1, R3, R5, R13; 5 bits for R6, R8, R9, R10; 8 bits for all others.
  - Unused bits are stored as 0.
  - The new value appears on the outputs the cycle after the WRITE sample (latency 1).
  - Level-sensitive: every WRITE cycle rewrites the register.
- WRITE, when not selected: ignored, registers unchanged.
- env_restart:
  - Asserted for exactly one cycle, the cycle after the first WRITE sample of a write phase (previous sampled mode != WRITE) with selected=1 and addr=13.
  - A held WRITE phase produces a single pulse.
  - Back-to-back write phases separated by at least one non-WRITE cycle produce one pulse each.
  - An R13 write of the same value still pulses.
- READ:
  - Qualified by selected; data_oe=1 and data_out=masked R[addr] in the cycle after each READ sample.
  - Unused bits read 0.
  - Otherwise data_oe=0 and data_out=8'h00.
- Modes are mutually exclusive, so address and data never change in the same cycle.
- Reset values:
  - R0–R15 = 0 and addr = 0.
  - selected = 1, so writes work without a prior latch.
  - data_out = 0, data_oe = 0, env_restart = 0.
  - The previous-mode register = INACTIVE.
- Reset mid write phase:
  - The reset value wins; no env_restart is generated in the reset cycle.
  - A WRITE still held after reset is treated as a new write phase and pulses if addr=13.
- Registered outputs are direct, glitch-free register bits with no combinational paths from bus inputs.

Optional Feature:
- Macro: PSG_BUS_SYNC_EN.
- When defined:
  - bdir, bc1 and data_in pass through a 2-flop synchronizer before decode.
  - All latencies above increase by 2 cycles.
  - Used when the CPU bus is asynchronous to clk.
  - Synchronizer flops reset to 0.
- When undefined: inputs are decoded directly; the latency figures above apply unchanged.

Test Plan:
- Reset, then read all 16 registers (LATCH n, READ) -> data_out=0x00 for each, data_oe=1 one cycle after each READ.
- LATCH 0x01, WRITE 0xFF, LATCH 0x00, WRITE 0x34 -> tone_period_a=12'hF34; reading R1 returns 0x0F.
- LATCH 0x0D, WRITE 0x0A held 5 cycles -> env_shape=4'hA from the cycle after the first WRITE; env_restart high exactly 1 cycle. Repeat after an INACTIVE cycle -> a second single pulse.
- CHIP_ADDR=0: LATCH 0x18, WRITE 0x55 -> R8 unchanged, READ gives data_oe=0. Then LATCH 0x08, WRITE 0x3F -> amp_a=5'h1F.
- WRITE of 0xFF to R6 and to R10 -> noise_period=5'h1F and amp_c=5'h1F; read-back of R6 returns 0x1F.
- Assert reset during a held WRITE to R13 -> all outputs 0 in the reset cycle. WRITE still held after reset releases -> a fresh env_restart pulse (addr reset to 0, so only if re-latched to 13; otherwise no pulse).
